// File: rtl/cdb_arbiter_if.sv
// Bus between the functional units / pipeline control and the CDB arbiter.
// slave = arbiter side, master = FU/ROB side.
interface cdb_arbiter_if #(
  parameter int NUM_FU        = 4,
  parameter int CDB_NUM_LANES = 2,
  parameter int ROB_SIZE_CLOG = 5,
  parameter int DATA_LEN      = 32
);
  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Handshake: an FU result transfers at a rising edge when fu_val[i] and
  // fu_rdy[i] are both high; fu_val[i] with fu_rdy[i] low drops the result
  // and raises the sticky ovf_err. CDB lanes have no back-pressure: a lane
  // with val_cdb high is broadcast and consumed in that same cycle.
  logic                                          flush;
  logic [NUM_FU-1:0]                             fu_val;
  logic [NUM_FU-1:0][ROB_SIZE_CLOG-1:0]          fu_robid;
  logic [NUM_FU-1:0][DATA_LEN-1:0]               fu_result;
  logic [NUM_FU-1:0]                             fu_rdy;
  logic [CDB_NUM_LANES-1:0]                      val_cdb;
  logic [CDB_NUM_LANES-1:0][ROB_SIZE_CLOG-1:0]   robid_cdb;
  logic [CDB_NUM_LANES-1:0][DATA_LEN-1:0]        result_cdb;
  logic                                          ovf_err;
  logic [PW-1:0]                                 dbg_rr_ptr;

  modport slave (
    input  flush, fu_val, fu_robid, fu_result,
    output fu_rdy, val_cdb, robid_cdb, result_cdb, ovf_err, dbg_rr_ptr
  );

  modport master (
    output flush, fu_val, fu_robid, fu_result,
    input  fu_rdy, val_cdb, robid_cdb, result_cdb, ovf_err, dbg_rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU result FIFOs feeding CDB_NUM_LANES registered broadcast lanes,
// granted round-robin starting from rr_ptr each cycle.
module cdb_arbiter #(
  parameter int NUM_FU        = 4,
  parameter int CDB_NUM_LANES = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROB_SIZE_CLOG = 5,
  parameter int DATA_LEN      = 32
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ROB_SIZE_CLOG + DATA_LEN;

  logic [EW-1:0] mem_q    [NUM_FU][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_FU];
  logic [AW-1:0] rd_ptr_q [NUM_FU];
  logic [CW-1:0] count_q  [NUM_FU];
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          ovf_q;

  logic [NUM_FU-1:0] rdy, push, pop;
  logic [CDB_NUM_LANES-1:0] val_d, val_q;
  logic [PW-1:0] lane_sel [CDB_NUM_LANES];
  logic [CDB_NUM_LANES-1:0][ROB_SIZE_CLOG-1:0] robid_d, robid_q;
  logic [CDB_NUM_LANES-1:0][DATA_LEN-1:0]      result_d, result_q;
  int arb_n;
  int arb_idx;

  // Ready comes from the registered count only, so a full FIFO being
  // popped this cycle still refuses a new result.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      rdy[i] = (count_q[i] < CW'(FIFO_DEPTH));
    end
  end

  assign push = bus.fu_val & rdy & {NUM_FU{~bus.flush}};

  always_comb begin
    pop      = '0;
    val_d    = '0;
    rr_ptr_d = rr_ptr_q;
    arb_n    = 0;
    arb_idx  = 0;
    for (int l = 0; l < CDB_NUM_LANES; l++) lane_sel[l] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_FU;
      if (count_q[arb_idx] != '0 && arb_n < CDB_NUM_LANES) begin
        pop[arb_idx]    = 1'b1;
        val_d[arb_n]    = 1'b1;
        lane_sel[arb_n] = PW'(arb_idx);
        rr_ptr_d        = PW'((arb_idx + 1) % NUM_FU);
        arb_n           = arb_n + 1;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < CDB_NUM_LANES; l++) begin
      robid_d[l]  = '0;
      result_d[l] = '0;
      if (val_d[l]) begin
        {robid_d[l], result_d[l]} = mem_q[lane_sel[l]][rd_ptr_q[lane_sel[l]]];
      end
    end
  end

  // Storage has no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {bus.fu_robid[i], bus.fu_result[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
      val_q    <= '0;
      robid_q  <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
      val_q    <= '0;
      robid_q  <= '0;
      result_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= wr_ptr_q[i] + AW'(push[i]);
        rd_ptr_q[i] <= rd_ptr_q[i] + AW'(pop[i]);
        count_q[i]  <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      rr_ptr_q <= rr_ptr_d;
      val_q    <= val_d;
      robid_q  <= robid_d;
      result_q <= result_d;
    end
  end

  // Overflow is sticky across flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         ovf_q <= 1'b0;
    else if (|(bus.fu_val & ~rdy))    ovf_q <= 1'b1;
  end

  assign bus.fu_rdy     = rdy;
  assign bus.val_cdb    = val_q;
  assign bus.robid_cdb  = robid_q;
  assign bus.result_cdb = result_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter with a queue-based reference
// model feeding a cycle-tagged expected-lane scoreboard.
module tb_cdb_arbiter;
  localparam int NF    = 4;
  localparam int NL    = 2;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int TW    = 16;
  localparam int EW    = RW + DW;
  localparam int W     = TW + 8 + EW;

  logic clk = 1'b0;
  logic rst_n;
  logic [TW-1:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1'b1;

  cdb_arbiter_if #(.NUM_FU(NF), .CDB_NUM_LANES(NL), .ROB_SIZE_CLOG(RW), .DATA_LEN(DW)) ifc ();

  cdb_arbiter #(
    .NUM_FU(NF), .CDB_NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .ROB_SIZE_CLOG(RW), .DATA_LEN(DW)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(ifc)
  );

  logic [W-1:0]  exp_q[$];
  logic [EW-1:0] mq[NF][$];
  int            m_rr;
  logic          m_ovf;
  int            n_checks = 0;
  int            n_err    = 0;
  bit            mon_en   = 0;
  logic [RW-1:0] drv_robid[NF];
  logic [DW-1:0] drv_res[NF];
  logic [W-1:0]  mon_got, mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NF-1:0] rdy_mask();
    logic [NF-1:0] m;
    for (int i = 0; i < NF; i++) m[i] = (mq[i].size() < DEPTH);
    return m;
  endfunction

  // Monitor: every visible lane must match the next expected entry, tagged
  // with the cycle it should appear in.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < NL; l++) begin
        if (ifc.val_cdb[l]) begin
          mon_got = {cyc, 8'(l), ifc.robid_cdb[l], ifc.result_cdb[l]};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_lane: got %0h expected none (cycle %0d)", mon_got, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("lane_entry", 64'(mon_got), 64'(mon_e));
          end
        end else begin
          check($sformatf("idle_lane%0d_zero", l), 64'({ifc.robid_cdb[l], ifc.result_cdb[l]}), 64'd0);
        end
      end
      while (exp_q.size() > 0 && exp_q[0][W-1 -: TW] <= cyc) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_err++;
        $display("FAIL missing_lane: got nothing expected %0h (cycle %0d)", mon_e, cyc);
      end
    end
  end

  // One cycle: check registered state against the model, drive inputs,
  // advance the model across the coming edge, then wait to the next negedge.
  task automatic step(input logic [NF-1:0] v, input logic fl);
    logic [NF-1:0] rdy_pre;
    logic [TW-1:0] tag;
    logic [EW-1:0] e;
    int n, idx, last;
    rdy_pre = rdy_mask();
    for (int i = 0; i < NF; i++) check($sformatf("fu_rdy%0d", i), 64'(ifc.fu_rdy[i]), 64'(rdy_pre[i]));
    check("ovf_err", 64'(ifc.ovf_err), 64'(m_ovf));
    check("rr_ptr", 64'(ifc.dbg_rr_ptr), 64'(m_rr));
    ifc.fu_val = v;
    ifc.flush  = fl;
    for (int i = 0; i < NF; i++) begin
      ifc.fu_robid[i]  = drv_robid[i];
      ifc.fu_result[i] = drv_res[i];
    end
    for (int i = 0; i < NF; i++) if (v[i] && !rdy_pre[i]) m_ovf = 1'b1;
    tag = cyc + 1'b1;
    if (fl) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      m_rr = 0;
    end else begin
      n = 0;
      last = 0;
      for (int k = 0; k < NF; k++) begin
        idx = (m_rr + k) % NF;
        if (mq[idx].size() > 0 && n < NL) begin
          e = mq[idx].pop_front();
          exp_q.push_back({tag, 8'(n), e});
          n++;
          last = idx;
        end
      end
      if (n > 0) m_rr = (last + 1) % NF;
      for (int i = 0; i < NF; i++) if (v[i] && rdy_pre[i]) mq[i].push_back({drv_robid[i], drv_res[i]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NF; i++) begin
      drv_robid[i] = RW'($urandom_range(0, 31));
      drv_res[i]   = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  initial begin
    int guard;
    rst_n         = 1'b0;
    ifc.flush     = 1'b0;
    ifc.fu_val    = '0;
    ifc.fu_robid  = '0;
    ifc.fu_result = '0;
    m_rr          = 0;
    m_ovf         = 1'b0;
    for (int i = 0; i < NF; i++) begin
      drv_robid[i] = '0;
      drv_res[i]   = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_val_cdb", 64'(ifc.val_cdb), 64'd0);
    check("reset_robid_cdb", 64'(ifc.robid_cdb), 64'd0);
    check("reset_result_cdb", 64'(ifc.result_cdb), 64'd0);
    check("reset_ovf", 64'(ifc.ovf_err), 64'd0);
    check("reset_fu_rdy", 64'(ifc.fu_rdy), 64'hF);
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // single result
    drv_robid[0] = 5'd5;
    drv_res[0]   = 32'hDEADBEEF;
    step(4'b0001, 1'b0);
    idle(3);

    // all four FUs in one cycle
    for (int i = 0; i < NF; i++) begin
      drv_robid[i] = RW'(i + 1);
      drv_res[i]   = $urandom;
    end
    step(4'b1111, 1'b0);
    idle(3);

    // fairness: all FIFOs kept non-empty
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step(rdy_mask(), 1'b0);
    end

    // backpressure on FU2, then a forced push while full
    guard = 0;
    while (mq[2].size() < DEPTH && guard < 20) begin
      rand_data();
      step(rdy_mask(), 1'b0);
      guard++;
    end
    check("fu2_filled", 64'(mq[2].size()), 64'(DEPTH));
    drv_robid[2] = 5'd31;
    drv_res[2]   = 32'hBAD0BAD0;
    step(4'b0100, 1'b0);
    idle(12);

    // pointer wrap on FU1, uncontended
    drv_res[1] = 32'h0000_1000;
    for (int k = 0; k < 10; k++) begin
      drv_robid[1] = RW'(k);
      drv_res[1]   = 32'h0000_1000 + 32'(k);
      step(4'b0010, 1'b0);
    end
    idle(3);

    // flush with entries buffered
    rand_data();
    step(4'b1111, 1'b0);
    rand_data();
    step(4'b1111, 1'b0);
    step('0, 1'b1);
    idle(4);

    // random traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      rand_data();
      step(4'($urandom_range(0, 15)) & rdy_mask(), ($urandom_range(0, 49) == 0));
    end
    idle(8);

    // asynchronous reset mid-burst
    rand_data();
    step(4'b1111, 1'b0);
    rand_data();
    step(4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_val_cdb", 64'(ifc.val_cdb), 64'd0);
    check("async_robid_cdb", 64'(ifc.robid_cdb), 64'd0);
    check("async_result_cdb", 64'(ifc.result_cdb), 64'd0);
    check("async_fu_rdy", 64'(ifc.fu_rdy), 64'hF);
    check("async_ovf", 64'(ifc.ovf_err), 64'd0);
    for (int i = 0; i < NF; i++) mq[i].delete();
    exp_q.delete();
    m_rr  = 0;
    m_ovf = 1'b0;
    ifc.fu_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drv_robid[3] = 5'd9;
    drv_res[3]   = 32'h1234_5678;
    step(4'b1000, 1'b0);
    idle(3);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL leftover_expected: got nothing expected %0h", mon_e);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
